ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
PS/2 device-to-host frame receiver. It consumes the ps2 clock/data pair that hps_io emits as the keyboard transmitter and recovers scan-code bytes into a small first-word-fall-through FIFO. Each Microcomputer variant's keyboard/terminal logic pops bytes from that FIFO. It replaces ad-hoc edge sampling with filtered, validated and time-bounded reception.

Parameters:
FILTER_LEN, 8, consecutive equal synchronized samples required before the filtered ps2 clock/data level changes.
TIMEOUT_CYC, 50000, max clk_sys cycles between falling edges inside one frame (1 ms at 50 MHz).
FIFO_DEPTH, 8, byte entries; power of two, at least 2.

Ports:
clk_sys      in   1  system clock
reset        in   1  synchronous, active-high reset
ps2_clk      in   1  PS/2 clock from transmitter, asynchronous
ps2_data     in   1  PS/2 data from transmitter, asynchronous
rd           in   1  pop strobe; ignored while valid=0
dout         out  8  FIFO head byte; holds 0x00 when empty
valid        out  1  FIFO not empty
parity_err   out  1  1-cycle pulse; frame dropped because parity is not odd
frame_err    out  1  1-cycle pulse; bad stop bit or timeout
overflow     out  1  1-cycle pulse; good byte dropped because FIFO full

Behaviour:
- Reset: synchronous, active-high (fixed). Takes priority over every other event.
  - dout=0, valid=0, all pulses 0.
  - FIFO pointers and count cleared; FSM to IDLE.
  - Filter outputs forced to 1; synchronizers preset to 1.
  - A reset asserted mid-frame discards that frame. Reception restarts at the next start bit.
- Input path:
  - 2-FF synchronizer per line.
  - Per-line saturating counter. The filtered level flips only after FILTER_LEN consecutive samples that differ from the current filtered level.
  - A shorter glitch resets the counter and produces no edge.
- Falling edge: filtered clock goes 1->0. This is a single-cycle event "fe". Data is sampled at fe from the filtered data line.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: at fe with data=0 (start bit) -> DATA; bit counter=0, shift register cleared, timer cleared. At fe with data=1 -> stay IDLE, no error.
  - DATA: at fe, shift data in LSB first. After the 8th bit -> PARITY.
  - PARITY: at fe, capture the bit -> STOP.
  - STOP: at fe, check odd parity across the 8 data bits plus the parity bit.
    - stop=1 and parity good -> push byte, go to IDLE.
    - stop=1 and parity bad -> parity_err, go to IDLE.
    - stop=0 -> frame_err, go to IDLE (regardless of parity).
- Timeout:
  - Timer counts in every state except IDLE and clears at each fe.
  - Reaching TIMEOUT_CYC-1 -> frame_err, back to IDLE, partial byte discarded.
  - fe and timeout in the same cycle: fe wins and the timer clears.
- Latency: valid and the new dout appear on the cycle after the stop-bit fe cycle (push registered).
- FIFO (first-word fall-through): dout always shows the head entry.
  - rd with valid=1 pops; the next head is visible the following cycle.
  - Push when full and rd=0: byte dropped, overflow pulses, contents unchanged.
  - Push when full and rd=1 in the same cycle: pop and push both succeed, count unchanged, no overflow.
  - Push when empty and rd=1 in the same cycle: rd ignored (valid=0).
  - Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- Error pulses: never asserted together. Each is at most one per frame.

Decomposition:
- Package ps2_rx_pkg:
  - state enum {IDLE, DATA, PARITY, STOP}
  - PS2_DATA_BITS=8
  - odd-parity function
- Sub-module ps2_rx_fifo (parameter DEPTH): push/pop/full/empty/head, with the simultaneous-push/pop-on-full rule above.
- Synchronizer, filter and FSM stay in ps2_kbd_rx.

Test Plan:
1. Clean frame for 0x1C (parity bit 0, stop 1), bit period 80 us at 50 MHz -> valid=1 one cycle after the stop fe; dout=0x1C; rd -> valid=0, dout=0x00.
2. Frame for 0x1C with parity bit 1 -> one parity_err pulse; valid stays 0. A following good 0xF0 frame is received.
3. Stop bit 0 -> frame_err. Separately, clock held high for 60000 cycles after the 4th data bit -> frame_err at cycle 50000 after the last fe; the next frame is received correctly.
4. 5-cycle low glitch on ps2_clk during IDLE, and 5-cycle glitches between real edges -> no extra bits; bytes 0x55 and 0xAA are received unchanged.
5. Send 9 bytes 0x01..0x09 with no reads -> FIFO holds 0x01..0x08; overflow pulses once at 0x09. Repeat with rd asserted at the 9th push cycle -> no overflow; after draining, the FIFO yields 0x02..0x09 in order.
6. Assert reset after the 5th data bit, then send 0x29 -> FIFO gets only 0x29, and no error pulses occur.

Source files
------------

// File: rtl/ps2_rx_pkg.sv
// Shared types and helpers for the PS/2 device-to-host receiver.
// Holds the frame FSM state encoding, data width and the parity helper.
package ps2_rx_pkg;

    localparam int PS2_DATA_BITS = 8;
    localparam int PS2_BIT_CNT_W = $clog2(PS2_DATA_BITS);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    // PS/2 frames carry odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Byte/status side of the PS/2 receiver: FIFO head, pop strobe and error pulses.
// The receiver is the master; the keyboard/terminal logic consuming bytes is the slave.
interface ps2_kbd_rx_if;
    import ps2_rx_pkg::*;

    logic                     rd;
    logic [PS2_DATA_BITS-1:0] dout;
    logic                     valid;
    logic                     parity_err;
    logic                     frame_err;
    logic                     overflow;

    modport master (
        input  rd,
        output dout,
        output valid,
        output parity_err,
        output frame_err,
        output overflow
    );

    modport slave (
        output rd,
        input  dout,
        input  valid,
        input  parity_err,
        input  frame_err,
        input  overflow
    );

endinterface

// File: rtl/ps2_rx_fifo.sv
// First-word-fall-through byte FIFO with a registered head; a push on full is
// accepted only when a pop frees a slot in the same cycle, otherwise it is dropped.
module ps2_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             overflow_q, overflow_d;

    logic empty;
    logic full;
    logic do_pop;
    logic do_push;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(do_push);
        rd_ptr_d   = rd_ptr_q + PW'(do_pop);
        count_d    = count_q + CW'(do_push) - CW'(do_pop);
        overflow_d = push & full & ~do_pop;
        head_d     = '0;
        // The head register is loaded with what will sit at the read pointer
        // next cycle; a byte landing there this cycle is forwarded from din.
        if (count_d != '0) begin
            if (do_push && (wr_ptr_q == rd_ptr_d)) begin
                head_d = din;
            end else begin
                head_d = mem[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            overflow_q <= overflow_d;
        end
    end

    assign head     = head_q;
    assign valid    = ~empty;
    assign overflow = overflow_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the clock/data pair,
// decodes 11-bit frames with parity, stop and inter-edge timeout checks, queues bytes.
module ps2_kbd_rx
    import ps2_rx_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_kbd_rx_if.master  host
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);

    logic [1:0] line_raw;
    logic [1:0] line_filt;

    assign line_raw = {ps2_data, ps2_clk};

    // Line 0 is the PS/2 clock, line 1 the PS/2 data; both idle high.
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
        logic          sync1_q, sync1_d;
        logic          sync2_q, sync2_d;
        logic          filt_q, filt_d;
        logic [FW-1:0] cnt_q, cnt_d;

        always_comb begin
            sync1_d = line_raw[gi];
            sync2_d = sync1_q;
            filt_d  = filt_q;
            cnt_d   = '0;
            if (sync2_q != filt_q) begin
                if (cnt_q == FW'(FILTER_LEN - 1)) begin
                    filt_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + FW'(1);
                end
            end
        end

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                filt_q  <= 1'b1;
                cnt_q   <= '0;
            end else begin
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
                filt_q  <= filt_d;
                cnt_q   <= cnt_d;
            end
        end

        assign line_filt[gi] = filt_q;
    end

    logic clk_filt;
    logic data_filt;
    logic clk_prev_q, clk_prev_d;
    logic fe;

    assign clk_filt  = line_filt[0];
    assign data_filt = line_filt[1];
    assign clk_prev_d = clk_filt;
    assign fe = clk_prev_q & ~clk_filt;

    ps2_state_t                 state_q, state_d;
    logic [PS2_BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [PS2_DATA_BITS-1:0]   shift_q, shift_d;
    logic                       par_q, par_d;
    logic [TW-1:0]              timer_q, timer_d;
    logic                       perr_q, perr_d;
    logic                       ferr_q, ferr_d;
    logic                       push;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        timer_d   = timer_q;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        push      = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (fe && !data_filt) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            DATA: begin
                if (fe) begin
                    shift_d   = {data_filt, shift_q[PS2_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + PS2_BIT_CNT_W'(1);
                    if (bit_cnt_q == PS2_BIT_CNT_W'(PS2_DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fe) begin
                    par_d   = data_filt;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fe) begin
                    state_d = IDLE;
                    if (!data_filt) begin
                        ferr_d = 1'b1;
                    end else if (odd_parity_ok(shift_q, par_q)) begin
                        push = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Inter-edge watchdog; an edge arriving on the expiry cycle still counts.
        if (state_q != IDLE) begin
            if (fe) begin
                timer_d = '0;
            end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d = IDLE;
                ferr_d  = 1'b1;
                timer_d = '0;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_prev_q <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            timer_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            clk_prev_q <= clk_prev_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            timer_q    <= timer_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    logic [PS2_DATA_BITS-1:0] fifo_head;
    logic                     fifo_valid;
    logic                     fifo_overflow;

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PS2_DATA_BITS)
    ) u_fifo (
        .clk      (clk_sys),
        .srst     (reset),
        .push     (push),
        .din      (shift_q),
        .pop      (host.rd),
        .head     (fifo_head),
        .valid    (fifo_valid),
        .overflow (fifo_overflow)
    );

    assign host.dout       = fifo_head;
    assign host.valid      = fifo_valid;
    assign host.parity_err = perr_q;
    assign host.frame_err  = ferr_q;
    assign host.overflow   = fifo_overflow;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: drives PS/2 frames on the raw pins and checks
// bytes, latency, error pulses, glitch rejection, timeout, overflow and reset.
module tb_ps2_kbd_rx;

    localparam int FL = 8;
    localparam int TO = 300;
    localparam int FD = 8;
    localparam int H  = 25;

    logic clk;
    logic reset;
    logic ps2_clk;
    logic ps2_data;

    int checks;
    int failures;
    int perr_cnt;
    int ferr_cnt;
    int ovf_cnt;
    int multi_cnt;
    int p0, f0, o0;
    int hit;
    logic [7:0] b;

    ps2_kbd_rx_if bus ();

    ps2_kbd_rx #(
        .FILTER_LEN  (FL),
        .TIMEOUT_CYC (TO),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk_sys  (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .host     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.parity_err === 1'b1) perr_cnt <= perr_cnt + 1;
        if (bus.frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if (bus.overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;
        if ((int'(bus.parity_err === 1'b1) + int'(bus.frame_err === 1'b1)
             + int'(bus.overflow === 1'b1)) > 1)
            multi_cnt <= multi_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic send_bit(input logic v, input bit glitch);
        ps2_data = v;
        if (glitch) begin
            repeat (8) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (5) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (12) @(negedge clk);
        end else begin
            repeat (H) @(negedge clk);
        end
        ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop,
                              input bit glitch, input bit rd_at_push);
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
        send_bit((~^d) ^ par_flip, glitch);
        ps2_data = stop;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        if (rd_at_push) begin
            // stop fe is seen 2 sync + FL filter cycles after the raw edge
            repeat (2 + FL) @(negedge clk);
            bus.rd = 1'b1;
            @(negedge clk);
            bus.rd = 1'b0;
            repeat (H - 3 - FL) @(negedge clk);
        end else begin
            repeat (H) @(negedge clk);
        end
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(bus.valid), 32'd1);
        check(tag, 32'(bus.dout), 32'(exp));
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
    endtask

    task automatic empty_check(input string tag);
        check({tag, "_valid"}, 32'(bus.valid), 32'd0);
        check({tag, "_dout"}, 32'(bus.dout), 32'h00);
    endtask

    initial begin
        checks = 0; failures = 0;
        perr_cnt = 0; ferr_cnt = 0; ovf_cnt = 0; multi_cnt = 0;
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; bus.rd = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(bus.dout), 32'h00);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_perr", 32'(bus.parity_err), 32'd0);
        check("rst_ferr", 32'(bus.frame_err), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        reset = 1'b0;
        repeat (H) @(negedge clk);

        // 1: clean 0x1C frame with exact push latency
        b = 8'h1C;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
        send_bit(1'b0, 1'b0);
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2 + FL) @(negedge clk);
        check("t1_valid_at_fe", 32'(bus.valid), 32'd0);
        @(negedge clk);
        check("t1_valid_lat", 32'(bus.valid), 32'd1);
        check("t1_dout", 32'(bus.dout), 32'h1C);
        repeat (H - 3 - FL) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (H) @(negedge clk);
        pop_check("t1_pop", 8'h1C);
        empty_check("t1_empty");

        // 2: bad parity then a good 0xF0
        p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t2_perr_count", 32'(perr_cnt - p0), 32'd1);
        check("t2_ferr_count", 32'(ferr_cnt - f0), 32'd0);
        check("t2_valid", 32'(bus.valid), 32'd0);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
        pop_check("t2_pop_f0", 8'hF0);
        empty_check("t2_empty");

        // 3a: stop bit 0
        f0 = ferr_cnt; p0 = perr_cnt;
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t3_stop_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("t3_stop_perr", 32'(perr_cnt - p0), 32'd0);
        check("t3_stop_valid", 32'(bus.valid), 32'd0);

        // 3b: clock stalls high after the 4th data bit
        f0 = ferr_cnt;
        b = 8'h1C;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i], 1'b0);
        ps2_data = 1'b1;
        hit = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (bus.frame_err === 1'b1 && hit == 0) hit = i;
        end
        // last fe at raw fall + 2 + FL; pulse visible TO+1 cycles later; raw fall was H cycles before loop
        check("t3_timeout_cycle", 32'(hit >= TO + 3 + FL - H - 2 && hit <= TO + 3 + FL - H + 2), 32'd1);
        check("t3_timeout_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("t3_timeout_valid", 32'(bus.valid), 32'd0);
        send_frame(8'h3A, 1'b0, 1'b1, 1'b0, 1'b0);
        pop_check("t3_pop_3a", 8'h3A);
        empty_check("t3_empty");

        // 4: glitches on ps2_clk in idle and between real edges
        p0 = perr_cnt; f0 = ferr_cnt;
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
        send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t4_perr_count", 32'(perr_cnt - p0), 32'd0);
        check("t4_ferr_count", 32'(ferr_cnt - f0), 32'd0);
        pop_check("t4_pop_55", 8'h55);
        pop_check("t4_pop_aa", 8'hAA);
        empty_check("t4_empty");

        // 5a: nine bytes without reads
        o0 = ovf_cnt;
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
        check("t5_ovf_before", 32'(ovf_cnt - o0), 32'd0);
        send_frame(8'h09, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t5_ovf_after", 32'(ovf_cnt - o0), 32'd1);
        for (int i = 1; i <= 8; i++) pop_check($sformatf("t5a_pop%0d", i), 8'(i));
        empty_check("t5a_empty");

        // 5b: rd coincides with the 9th push on a full FIFO
        o0 = ovf_cnt;
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h09, 1'b0, 1'b1, 1'b0, 1'b1);
        check("t5b_ovf", 32'(ovf_cnt - o0), 32'd0);
        for (int i = 2; i <= 9; i++) pop_check($sformatf("t5b_pop%0d", i), 8'(i));
        empty_check("t5b_empty");

        // 6: reset after the 5th data bit, then 0x29
        p0 = perr_cnt; f0 = ferr_cnt; o0 = ovf_cnt;
        b = 8'h29;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(b[i], 1'b0);
        ps2_data = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (H) @(negedge clk);
        send_frame(8'h29, 1'b0, 1'b1, 1'b0, 1'b0);
        pop_check("t6_pop_29", 8'h29);
        empty_check("t6_empty");
        check("t6_err_pulses", 32'((perr_cnt - p0) + (ferr_cnt - f0) + (ovf_cnt - o0)), 32'd0);

        check("pulses_exclusive", 32'(multi_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
